// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// Drives the 4-digit display's values bus plus overflow flag and leading-zero blanking mask.
module bin_to_bcd_seq #(
   parameter int unsigned IN_WIDTH = 14,
   parameter int unsigned DIGITS   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IN_WIDTH-1:0]   bin,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  out_valid,
   output logic                  overflow,
   output logic [DIGITS-1:0]     lz_mask
);

   localparam int unsigned BCD_W   = 4 * DIGITS;
   localparam int unsigned CNT_W   = $clog2(IN_WIDTH + 1);
   localparam int unsigned CMP_W   = (IN_WIDTH > 32) ? IN_WIDTH : 32;
   localparam int unsigned MAX_VAL = (10 ** DIGITS) - 1;
   localparam int unsigned JOIN_W  = BCD_W + IN_WIDTH;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t               state, state_next;
   logic [IN_WIDTH-1:0]  shift_reg, shift_next;
   logic [BCD_W-1:0]     scratch, scratch_next;
   logic [CNT_W-1:0]     cnt, cnt_next;
   logic                 ovf_pending, ovf_pending_next;
   logic [BCD_W-1:0]     bcd_next;
   logic                 overflow_next;
   logic [DIGITS-1:0]    lz_mask_next;
   logic                 out_valid_next;
   logic                 in_ready_next;

   logic [BCD_W-1:0]     adj;
   logic [JOIN_W-1:0]    joined;
   logic [BCD_W-1:0]     shifted;
   logic [DIGITS-1:0]    lz_calc;
   logic                 all_zero;

   // State and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         shift_reg   <= '0;
         scratch     <= '0;
         cnt         <= '0;
         ovf_pending <= 1'b0;
         bcd         <= '0;
         overflow    <= 1'b0;
         lz_mask     <= {{(DIGITS-1){1'b1}}, 1'b0};
         out_valid   <= 1'b0;
         in_ready    <= 1'b1;
      end else begin
         state       <= state_next;
         shift_reg   <= shift_next;
         scratch     <= scratch_next;
         cnt         <= cnt_next;
         ovf_pending <= ovf_pending_next;
         bcd         <= bcd_next;
         overflow    <= overflow_next;
         lz_mask     <= lz_mask_next;
         out_valid   <= out_valid_next;
         in_ready    <= in_ready_next;
      end
   end

   // Next-state, datapath step and registered-output values
   always_comb begin
      state_next       = state;
      shift_next       = shift_reg;
      scratch_next     = scratch;
      cnt_next         = cnt;
      ovf_pending_next = ovf_pending;
      bcd_next         = bcd;
      overflow_next    = overflow;
      lz_mask_next     = lz_mask;
      adj              = scratch;
      lz_calc          = '0;
      all_zero         = 1'b1;

      // Add-3 correction precedes the shift; the top digit's carry falls off the end
      for (int k = 0; k < int'(DIGITS); k++) begin
         if (scratch[4*k +: 4] >= 4'd5)
            adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
      end
      joined  = {adj, shift_reg} << 1;
      shifted = joined[JOIN_W-1:IN_WIDTH];

      for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
         all_zero   = all_zero & (shifted[4*k +: 4] == 4'd0);
         lz_calc[k] = all_zero;
      end

      case (state)
         IDLE: begin
            if (in_valid) begin
               shift_next       = bin;
               scratch_next     = '0;
               cnt_next         = CNT_W'(IN_WIDTH);
               ovf_pending_next = CMP_W'(bin) > CMP_W'(MAX_VAL);
               state_next       = SHIFT;
            end
         end
         SHIFT: begin
            scratch_next = shifted;
            shift_next   = joined[IN_WIDTH-1:0];
            cnt_next     = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               state_next = DONE;
               if (ovf_pending) begin
                  bcd_next      = '1;
                  overflow_next = 1'b1;
                  lz_mask_next  = '0;
               end else begin
                  bcd_next      = shifted;
                  overflow_next = 1'b0;
                  lz_mask_next  = lz_calc;
               end
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase

      in_ready_next  = (state_next == IDLE);
      out_valid_next = (state_next == DONE);
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq: cycle-exact handshake, results,
// overflow, leading-zero mask, back-to-back acceptance, mid-conversion reset and output hold.
module tb_bin_to_bcd_seq;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [13:0] bin;
   logic [15:0] bcd;
   logic        out_valid;
   logic        overflow;
   logic [3:0]  lz_mask;

   int checks = 0;
   int errors = 0;

   bin_to_bcd_seq #(.IN_WIDTH(14), .DIGITS(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bin       (bin),
      .bcd       (bcd),
      .out_valid (out_valid),
      .overflow  (overflow),
      .lz_mask   (lz_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Bounded wait at negedge until the converter is idle
   task automatic wait_ready;
      int n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("ready_timeout", 32'(in_ready), 32'd1);
   endtask

   // One conversion with per-cycle handshake checks; acceptance edge ends cycle 0
   task automatic convert(input int v, input logic [15:0] eb, input logic eo, input logic [3:0] el);
      wait_ready();
      bin      = 14'(v);
      in_valid = 1'b1;
      for (int cyc = 1; cyc <= 16; cyc++) begin
         @(negedge clk);
         in_valid = 1'b0;
         check("in_ready", 32'(in_ready), 32'(cyc == 16));
         check("out_valid", 32'(out_valid), 32'(cyc == 15));
         if (cyc == 15) begin
            check("bcd", 32'(bcd), 32'(eb));
            check("overflow", 32'(overflow), 32'(eo));
            check("lz_mask", 32'(lz_mask), 32'(el));
         end
      end
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      bin      = '0;
      repeat (2) @(negedge clk);
      check("rst_bcd", 32'(bcd), 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_lz", 32'(lz_mask), 32'b1110);
      check("rst_ready", 32'(in_ready), 32'd1);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", 32'(in_ready), 32'd1);

      // Basic value and leading-zero patterns
      convert(1234, 16'h1234, 1'b0, 4'b0000);
      convert(0,    16'h0000, 1'b0, 4'b1110);
      convert(7,    16'h0007, 1'b0, 4'b1110);
      convert(40,   16'h0040, 1'b0, 4'b1100);

      // Range boundary and overflow
      convert(9999,  16'h9999, 1'b0, 4'b0000);
      convert(10000, 16'hFFFF, 1'b1, 4'b0000);
      convert(16383, 16'hFFFF, 1'b1, 4'b0000);

      // in_valid held high; bin changes mid-conversion; back-to-back acceptance at cycle 16
      wait_ready();
      bin      = 14'd42;
      in_valid = 1'b1;
      for (int cyc = 1; cyc <= 31; cyc++) begin
         @(negedge clk);
         if (cyc == 5)  bin = 14'd815;
         if (cyc == 17) in_valid = 1'b0;
         check("b2b_ready", 32'(in_ready), 32'(cyc == 16));
         check("b2b_out_valid", 32'(out_valid), 32'(cyc == 15 || cyc == 31));
         if (cyc == 15) begin
            check("b2b_bcd0", 32'(bcd), 32'h0042);
            check("b2b_lz0", 32'(lz_mask), 32'b1100);
         end
         if (cyc == 31) begin
            check("b2b_bcd1", 32'(bcd), 32'h0815);
            check("b2b_lz1", 32'(lz_mask), 32'b1000);
         end
      end

      // Reset mid-conversion aborts without a result pulse
      wait_ready();
      bin      = 14'd5678;
      in_valid = 1'b1;
      for (int cyc = 1; cyc <= 6; cyc++) begin
         @(negedge clk);
         in_valid = 1'b0;
         check("abort_busy", 32'(in_ready), 32'd0);
         if (cyc == 6) rst = 1'b1;
      end
      @(negedge clk);
      rst = 1'b0;
      check("abort_ready", 32'(in_ready), 32'd1);
      check("abort_bcd", 32'(bcd), 32'h0);
      check("abort_lz", 32'(lz_mask), 32'b1110);
      check("abort_overflow", 32'(overflow), 32'd0);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("abort_no_pulse", 32'(out_valid), 32'd0);
      end
      convert(321, 16'h0321, 1'b0, 4'b1000);

      // Outputs hold while idle
      convert(1234, 16'h1234, 1'b0, 4'b0000);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         check("hold_bcd", 32'(bcd), 32'h1234);
         check("hold_out_valid", 32'(out_valid), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter (shift-and-add-3 / double dabble), one result bit per clock. Sits directly upstream of the 4-digit multiplexed hex display driver. Its bcd output connects straight to the driver's 16-bit values bus, so a binary count renders as decimal digits. Also supplies an overflow flag and a leading-zero mask for display blanking.

Parameters:
IN_WIDTH, 14, width of binary input; 14 covers 0..9999.
DIGITS, 4, number of BCD digits produced; output width is 4*DIGITS.

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  bin is valid; transfer occurs when in_valid & in_ready at a rising clk edge
in_ready  output  1  converter idle and able to accept
bin  input  IN_WIDTH  unsigned binary value to convert
bcd  output  4*DIGITS  registered result; digit k at bits [4k+3:4k], digit 0 is least significant
out_valid  output  1  one-cycle pulse: bcd/overflow/lz_mask updated this cycle
overflow  output  1  registered; last accepted bin exceeded 10^DIGITS-1
lz_mask  output  DIGITS  registered; bit k=1 when digit k is a leading zero. Bit 0 is always 0.

Behaviour:
- Reset: already decided — reset rst, synchronous, active-high; clock clk.
  - On a reset edge: state=IDLE, bcd=0, out_valid=0, overflow=0, lz_mask={DIGITS-1 ones, 0}.
  - Internal shift and scratch registers are cleared.
  - in_ready=1 from the first cycle after reset.
- State machine: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch bin into the shift register, clear the BCD scratch register, load the bit counter with IN_WIDTH.
  - Latch ovf_pending = (bin > 10^DIGITS-1), as an unsigned compare on a localparam constant.
  - Go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each cycle, first add 3 to every scratch digit >= 5, then shift {scratch, shift_reg} left by 1, bringing in the MSB of bin.
  - Decrement the counter. After exactly IN_WIDTH SHIFT cycles, go to DONE.
  - Scratch digit overflow above the top digit is discarded.
- DONE:
  - One cycle; in_ready=0, out_valid=1.
  - bcd, overflow and lz_mask update on the edge that enters DONE, so they are valid together with out_valid.
  - If ovf_pending: bcd={DIGITS{4'hF}}, overflow=1, lz_mask=0. The display then shows "FFFF".
  - Else: bcd=scratch, overflow=0, lz_mask[k]=1 iff digits k..DIGITS-1 are all zero, for k>=1.
  - Next state is IDLE.
- Latency:
  - Acceptance edge at cycle 0; out_valid is high during cycle IN_WIDTH+1 (cycle 15 for defaults).
  - Latency is constant regardless of value or overflow.
  - Throughput: one conversion per IN_WIDTH+2 cycles. The earliest next acceptance is the edge ending the DONE cycle+1, i.e. cycle IN_WIDTH+2.
- Outputs hold between conversions. bcd, overflow and lz_mask change only on the edge entering DONE, or on reset.
- in_valid while in_ready=0 is ignored. No buffering: the upstream block must hold bin and in_valid until in_ready is high.
- bin changing during SHIFT has no effect.
- Reset mid-conversion: abort, no out_valid pulse, outputs return to reset values.
- rst has priority over all other events, including an acceptance in the same cycle.
- If IN_WIDTH is too small to exceed 10^DIGITS-1, overflow is constant 0.

Test Plan:
1. Reset, then bin=1234 with in_valid pulsed at cycle 0 -> in_ready=0 during cycles 1..15; out_valid=1 only in cycle 15; bcd=16'h1234, overflow=0, lz_mask=4'b0000.
2. bin=0 -> bcd=16'h0000, lz_mask=4'b1110. bin=7 -> bcd=16'h0007, lz_mask=4'b1110. bin=40 -> bcd=16'h0040, lz_mask=4'b1100.
3. bin=9999 -> bcd=16'h9999, overflow=0. bin=10000 -> bcd=16'hFFFF, overflow=1, lz_mask=0, out_valid still at cycle 15. bin=16383 -> same FFFF/overflow result.
4. in_valid held high continuously with bin=0042 then changed to 0815 mid-conversion -> first result 16'h0042. Second acceptance at exactly cycle 16 with bin=0815; its out_valid at cycle 31 with bcd=16'h0815. No acceptance occurs while in_ready=0.
5. Accept 5678, assert rst for one cycle at cycle 6 -> no out_valid pulse, bcd=0, lz_mask=4'b1110, in_ready=1 the cycle after reset. A new conversion of 0321 then yields 16'h0321.
6. Outputs hold: after a 1234 result, idle 100 cycles with in_valid=0 -> bcd stays 16'h1234 and out_valid stays 0 throughout.
